// File: rtl/pic_cmd_sequencer.sv
// 8259-style PIC command/initialization sequencer: bus sampling, ICW1..ICW4 sequencing,
// OCW decode, data-buffer steering and read-back mux. Define PIC_CASCADE_EN to keep ICW3.
module pic_cmd_sequencer #(
  parameter logic [7:0] IMR_RESET      = 8'hFF,
  parameter logic [4:0] VEC_BASE_RESET = 5'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       rd_n,
  input  logic       wr_n,
  input  logic       a0,
  input  logic [7:0] din,
  input  logic [7:0] irr,
  input  logic [7:0] isr,
  input  logic [7:0] poll_word,
  output logic       buf_r,
  output logic       buf_w,
  output logic [7:0] dout,
  output logic       init_done,
  output logic [4:0] vec_base,
  output logic       ltim,
  output logic       sngl,
  output logic [7:0] icw3,
  output logic [4:0] icw4,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [7:0] ocw2,
  output logic       smm,
  output logic       poll_ack
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ICW2 = 3'd1,
`ifdef PIC_CASCADE_EN
    S_WAIT_ICW3 = 3'd2,
`endif
    S_WAIT_ICW4 = 3'd3,
    S_READY     = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_wr_act, r_rd_act, r_wa0, r_ra0;
  logic [7:0] r_wdat;
  logic       r_ic4, r_rr_sel, r_poll_pend;
  logic       r_buf_r, r_buf_w, r_ocw2_valid, r_poll_ack, r_ltim, r_smm;
  logic [7:0] r_dout, r_imr, r_ocw2;
  logic [4:0] r_vec_base, r_icw4;
`ifdef PIC_CASCADE_EN
  logic       r_sngl;
  logic [7:0] r_icw3;
`endif

  logic w_wr_active, w_rd_active, w_commit, w_rd_end;
  logic w_icw1, w_ocw1, w_ocw2, w_ocw3, w_ld_icw2, w_ld_icw4;
  logic w_sngl;

  // Simultaneous rd/wr strobes resolve as a write.
  assign w_wr_active = ~cs_n & ~wr_n;
  assign w_rd_active = ~cs_n & ~rd_n & wr_n;
  assign w_commit    = r_wr_act & ~w_wr_active;
  assign w_rd_end    = r_rd_act & ~w_rd_active;

  assign w_icw1    = w_commit & ~r_wa0 & r_wdat[4];
  assign w_ld_icw2 = w_commit & r_wa0 & (r_state == S_WAIT_ICW2);
  assign w_ld_icw4 = w_commit & r_wa0 & (r_state == S_WAIT_ICW4);
  assign w_ocw1    = w_commit & r_wa0 & (r_state == S_READY);
  assign w_ocw2    = w_commit & ~r_wa0 & (r_wdat[4:3] == 2'b00) & (r_state == S_READY);
  assign w_ocw3    = w_commit & ~r_wa0 & (r_wdat[4:3] == 2'b01) & (r_state == S_READY);

`ifdef PIC_CASCADE_EN
  assign w_sngl = r_sngl;
  assign icw3   = r_icw3;
`else
  assign w_sngl = 1'b1;
  assign icw3   = 8'h00;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_icw1) begin
      w_state_nxt = S_WAIT_ICW2;
    end else if (w_commit && r_wa0) begin
      case (r_state)
        S_WAIT_ICW2: begin
          if (!w_sngl)
`ifdef PIC_CASCADE_EN
            w_state_nxt = S_WAIT_ICW3;
`else
            w_state_nxt = S_WAIT_ICW4;
`endif
          else if (r_ic4) w_state_nxt = S_WAIT_ICW4;
          else            w_state_nxt = S_READY;
        end
`ifdef PIC_CASCADE_EN
        S_WAIT_ICW3: w_state_nxt = r_ic4 ? S_WAIT_ICW4 : S_READY;
`endif
        S_WAIT_ICW4: w_state_nxt = S_READY;
        default:     w_state_nxt = r_state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_act     <= 1'b0;
      r_rd_act     <= 1'b0;
      r_wa0        <= 1'b0;
      r_ra0        <= 1'b0;
      r_wdat       <= 8'h00;
      r_buf_r      <= 1'b1;
      r_buf_w      <= 1'b1;
      r_dout       <= 8'h00;
      r_vec_base   <= VEC_BASE_RESET;
      r_ltim       <= 1'b0;
      r_ic4        <= 1'b0;
      r_icw4       <= 5'h00;
      r_imr        <= IMR_RESET;
      r_ocw2       <= 8'h00;
      r_ocw2_valid <= 1'b0;
      r_smm        <= 1'b0;
      r_rr_sel     <= 1'b0;
      r_poll_pend  <= 1'b0;
      r_poll_ack   <= 1'b0;
`ifdef PIC_CASCADE_EN
      r_sngl       <= 1'b1;
      r_icw3       <= 8'h00;
`endif
    end else begin
      r_wr_act     <= w_wr_active;
      r_rd_act     <= w_rd_active;
      if (w_wr_active) begin
        r_wdat <= din;
        r_wa0  <= a0;
      end
      if (w_rd_active) r_ra0 <= a0;
      r_buf_r      <= ~w_rd_active;
      r_buf_w      <= ~w_wr_active;
      r_ocw2_valid <= w_ocw2;
      r_poll_ack   <= 1'b0;

      if (r_poll_pend && !a0) r_dout <= poll_word;
      else if (a0)            r_dout <= r_imr;
      else                    r_dout <= r_rr_sel ? isr : irr;

      if (w_icw1) begin
        r_ltim      <= r_wdat[3];
        r_ic4       <= r_wdat[0];
        r_imr       <= IMR_RESET;
        r_smm       <= 1'b0;
        r_rr_sel    <= 1'b0;
        r_poll_pend <= 1'b0;
        r_icw4      <= 5'h00;
`ifdef PIC_CASCADE_EN
        r_sngl      <= r_wdat[1];
`endif
      end else begin
        if (w_ld_icw2) r_vec_base <= r_wdat[7:3];
`ifdef PIC_CASCADE_EN
        if (w_commit && r_wa0 && r_state == S_WAIT_ICW3) r_icw3 <= r_wdat;
`endif
        if (w_ld_icw4) r_icw4 <= r_wdat[4:0];
        if (w_ocw1)    r_imr  <= r_wdat;
        if (w_ocw2)    r_ocw2 <= r_wdat;
        if (w_ocw3) begin
          if (r_wdat[1]) r_rr_sel <= r_wdat[0];
          if (r_wdat[6]) r_smm    <= r_wdat[5];
        end
        // A poll request survives only until the next completed bus cycle.
        if (w_ocw3 && r_wdat[2]) begin
          r_poll_pend <= 1'b1;
        end else if (w_commit && r_poll_pend) begin
          r_poll_pend <= 1'b0;
        end else if (w_rd_end && r_poll_pend && !r_ra0) begin
          r_poll_pend <= 1'b0;
          r_poll_ack  <= 1'b1;
        end
      end
    end
  end

  assign buf_r      = r_buf_r;
  assign buf_w      = r_buf_w;
  assign dout       = r_dout;
  assign init_done  = (r_state == S_READY);
  assign vec_base   = r_vec_base;
  assign ltim       = r_ltim;
  assign sngl       = w_sngl;
  assign icw4       = r_icw4;
  assign imr        = r_imr;
  assign ocw2_valid = r_ocw2_valid;
  assign ocw2       = r_ocw2;
  assign smm        = r_smm;
  assign poll_ack   = r_poll_ack;

endmodule

// File: tb/tb_pic_cmd_sequencer.sv
// Randomized self-checking bench for pic_cmd_sequencer against a queue-based
// model of the ICW sequence and OCW effects.
module tb_pic_cmd_sequencer;
  logic       clk = 1'b0;
  logic       rst_n, cs_n, rd_n, wr_n, a0;
  logic [7:0] din, irr, isr, poll_word;
  logic       buf_r, buf_w, init_done, ltim, sngl, ocw2_valid, smm, poll_ack;
  logic [7:0] dout, icw3, imr, ocw2;
  logic [4:0] vec_base, icw4;

  pic_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a0(a0),
    .din(din), .irr(irr), .isr(isr), .poll_word(poll_word),
    .buf_r(buf_r), .buf_w(buf_w), .dout(dout), .init_done(init_done),
    .vec_base(vec_base), .ltim(ltim), .sngl(sngl), .icw3(icw3), .icw4(icw4),
    .imr(imr), .ocw2_valid(ocw2_valid), .ocw2(ocw2), .smm(smm), .poll_ack(poll_ack)
  );

  always #5 clk = ~clk;

`ifdef PIC_CASCADE_EN
  localparam bit CASC = 1'b1;
`else
  localparam bit CASC = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // Reference model: pending ICW numbers are kept in a queue.
  logic       m_init, m_ltim, m_sngl, m_ic4, m_smm, m_rr, m_poll;
  logic [4:0] m_vec, m_icw4;
  logic [7:0] m_icw3, m_imr, m_ocw2;
  int         m_q[$];

  function automatic void model_reset();
    m_init = 0; m_ltim = 0; m_sngl = 1; m_ic4 = 0; m_smm = 0; m_rr = 0; m_poll = 0;
    m_vec = 5'h00; m_icw4 = 5'h00; m_icw3 = 8'h00; m_imr = 8'hFF; m_ocw2 = 8'h00;
    m_q.delete();
  endfunction

  function automatic void model_write(input logic a, input logic [7:0] d, output logic pulse);
    int k;
    pulse = 1'b0;
    if (!a && d[4]) begin
      m_ltim = d[3]; m_sngl = CASC ? d[1] : 1'b1; m_ic4 = d[0];
      m_imr = 8'hFF; m_smm = 0; m_rr = 0; m_poll = 0; m_init = 0; m_icw4 = 5'h00;
      m_q.delete();
      m_q.push_back(2);
      if (!m_sngl) m_q.push_back(3);
      if (m_ic4)   m_q.push_back(4);
      return;
    end
    m_poll = 1'b0;
    if (!m_init) begin
      if (a && m_q.size() > 0) begin
        k = m_q.pop_front();
        if (k == 2)      m_vec  = d[7:3];
        else if (k == 3) m_icw3 = d;
        else             m_icw4 = d[4:0];
        if (m_q.size() == 0) m_init = 1'b1;
      end
    end else if (a) begin
      m_imr = d;
    end else if (d[4:3] == 2'b00) begin
      m_ocw2 = d; pulse = 1'b1;
    end else begin
      if (d[2]) m_poll = 1'b1;
      if (d[1]) m_rr   = d[0];
      if (d[6]) m_smm  = d[5];
    end
  endfunction

  function automatic logic [37:0] model_snap();
    return {m_init, m_vec, m_ltim, m_sngl, m_icw3, m_icw4, m_imr, m_ocw2, m_smm};
  endfunction

  function automatic logic [37:0] dut_snap();
    return {init_done, vec_base, ltim, sngl, icw3, icw4, imr, ocw2, smm};
  endfunction

  // Drives one write (1-3 active cycles, junk before the final value, optional
  // simultaneous rd_n) and returns ocw2_valid on the two cycles after commit.
  task automatic bus_write(input logic a, input logic [7:0] d,
                           output logic o_bufw, output logic o_p1, output logic o_p2,
                           output logic exp_p);
    int n = $urandom_range(1, 3);
    @(negedge clk);
    cs_n = 1'b0; wr_n = 1'b0; rd_n = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
    for (int i = 0; i < n; i++) begin
      din = (i == n - 1) ? d : 8'($urandom);
      a0  = (i == n - 1) ? a : 1'($urandom);
      @(posedge clk); #1;
      if (i == 0) o_bufw = buf_w;
      @(negedge clk);
    end
    cs_n = 1'b1; wr_n = 1'b1; rd_n = 1'b1;
    model_write(a, d, exp_p);
    @(posedge clk); #1; o_p1 = ocw2_valid;
    @(posedge clk); #1; o_p2 = ocw2_valid;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] o_dout, output logic [7:0] e_dout,
                          output logic o_bufr, output logic o_bufw,
                          output logic o_ack, output logic e_ack);
    @(negedge clk);
    cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b1; a0 = a;
    e_dout = (m_poll && !a) ? poll_word : a ? m_imr : (m_rr ? isr : irr);
    @(posedge clk); #1;
    o_dout = dout; o_bufr = buf_r; o_bufw = buf_w;
    @(negedge clk);
    cs_n = 1'b1; rd_n = 1'b1;
    e_ack = m_poll && !a;
    if (e_ack) m_poll = 1'b0;
    @(posedge clk); #1; o_ack = poll_ack;
  endtask

  logic       s_bufw, s_p1, s_p2, e_p, s_bufr, s_ack, e_ack;
  logic [7:0] s_dout, e_dout;

  task automatic do_reset();
    @(negedge clk);
    cs_n = 1; rd_n = 1; wr_n = 1; a0 = 0; din = 0; irr = 0; isr = 0; poll_word = 0;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({buf_r, buf_w, dout, ocw2_valid, poll_ack} !== {1'b1, 1'b1, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_pins got %h exp %h", {buf_r, buf_w, dout, ocw2_valid, poll_ack}, 12'hC00);
    end
    n_vec++;
    if (dut_snap() !== model_snap()) begin
      n_err++; $display("FAIL reset_regs got %h exp %h", dut_snap(), model_snap());
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    bus_read(1'b1, s_dout, e_dout, s_bufr, s_bufw, s_ack, e_ack);
    n_vec++;
    if ({s_bufr, s_bufw} !== 2'b01) begin
      n_err++; $display("FAIL read_dir got %b exp 01", {s_bufr, s_bufw});
    end
    n_vec++;
    if (s_dout !== 8'hFF || init_done !== 1'b0) begin
      n_err++; $display("FAIL reset_read got dout=%h init=%b exp dout=ff init=0", s_dout, init_done);
    end
  endtask

  task automatic test_init_single();
    bus_write(1'b0, 8'h13, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if (s_bufw !== 1'b0 || buf_r !== 1'b1) begin
      n_err++; $display("FAIL write_dir got buf_w=%b buf_r=%b exp 0/1", s_bufw, buf_r);
    end
    bus_write(1'b1, 8'h08, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h01, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if ({init_done, vec_base, sngl, ltim, icw4} !== {1'b1, 5'h01, 1'b1, 1'b0, 5'h01}) begin
      n_err++;
      $display("FAIL init_single got %h exp %h", {init_done, vec_base, sngl, ltim, icw4},
               {1'b1, 5'h01, 1'b1, 1'b0, 5'h01});
    end
  endtask

  task automatic test_init_cascade();
    bus_write(1'b0, 8'h11, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h20, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h04, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h1D, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if (dut_snap() !== model_snap()) begin
      n_err++; $display("FAIL init_cascade got %h exp %h", dut_snap(), model_snap());
    end
    n_vec++;
    if (CASC ? ({icw3, icw4, imr} !== {8'h04, 5'h1D, 8'hFF}) : ({icw3, icw4, imr} !== {8'h00, 5'h04, 8'h1D})) begin
      n_err++; $display("FAIL cascade_third_byte got icw3=%h icw4=%h imr=%h", icw3, icw4, imr);
    end
  endtask

  task automatic test_ocw12();
    bus_write(1'b0, 8'h13, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h08, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h01, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h5A, s_bufw, s_p1, s_p2, e_p);
    bus_read(1'b1, s_dout, e_dout, s_bufr, s_bufw, s_ack, e_ack);
    n_vec++;
    if (s_dout !== 8'h5A) begin
      n_err++; $display("FAIL ocw1_readback got %h exp 5a", s_dout);
    end
    bus_write(1'b0, 8'h20, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if ({s_p1, s_p2, ocw2} !== {1'b1, 1'b0, 8'h20}) begin
      n_err++; $display("FAIL ocw2_pulse got p1=%b p2=%b ocw2=%h exp 1 0 20", s_p1, s_p2, ocw2);
    end
  endtask

  task automatic test_poll();
    @(negedge clk); isr = 8'h04; irr = 8'h91; poll_word = 8'h83;
    bus_write(1'b0, 8'h0B, s_bufw, s_p1, s_p2, e_p);
    bus_read(1'b0, s_dout, e_dout, s_bufr, s_bufw, s_ack, e_ack);
    n_vec++;
    if (s_dout !== 8'h04) begin
      n_err++; $display("FAIL read_isr got %h exp 04", s_dout);
    end
    bus_write(1'b0, 8'h0C, s_bufw, s_p1, s_p2, e_p);
    bus_read(1'b0, s_dout, e_dout, s_bufr, s_bufw, s_ack, e_ack);
    n_vec++;
    if ({s_dout, s_ack} !== {8'h83, 1'b1}) begin
      n_err++; $display("FAIL poll_read got dout=%h ack=%b exp 83 1", s_dout, s_ack);
    end
    @(posedge clk); #1;
    n_vec++;
    if (poll_ack !== 1'b0) begin
      n_err++; $display("FAIL poll_ack_width got %b exp 0", poll_ack);
    end
    bus_read(1'b0, s_dout, e_dout, s_bufr, s_bufw, s_ack, e_ack);
    n_vec++;
    if ({s_dout, s_ack} !== {8'h04, 1'b0}) begin
      n_err++; $display("FAIL post_poll_read got dout=%h ack=%b exp 04 0", s_dout, s_ack);
    end
  endtask

  task automatic test_reinit();
    bus_write(1'b0, 8'h13, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h08, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b0, 8'h13, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if ({imr, init_done} !== {8'hFF, 1'b0}) begin
      n_err++; $display("FAIL reinit got imr=%h init=%b exp ff 0", imr, init_done);
    end
    bus_write(1'b0, 8'h20, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if ({s_p1, s_p2, ocw2, init_done} !== {1'b0, 1'b0, m_ocw2, 1'b0}) begin
      n_err++; $display("FAIL ignored_ocw2 got p=%b%b ocw2=%h exp 00 %h", s_p1, s_p2, ocw2, m_ocw2);
    end
    bus_write(1'b1, 8'hF0, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h03, s_bufw, s_p1, s_p2, e_p);
    n_vec++;
    if (dut_snap() !== model_snap()) begin
      n_err++; $display("FAIL reinit_complete got %h exp %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_reset_mid_write();
    @(negedge clk); cs_n = 1'b0; wr_n = 1'b0; a0 = 1'b1; din = 8'h00;
    @(posedge clk); #2;
    rst_n = 1'b0;
    model_reset();
    @(negedge clk); cs_n = 1'b1; wr_n = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if (dut_snap() !== model_snap()) begin
      n_err++; $display("FAIL reset_mid_write got %h exp %h", dut_snap(), model_snap());
    end
  endtask

  task automatic test_random();
    logic       a;
    logic [7:0] d;
    bus_write(1'b0, 8'h13, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h40, s_bufw, s_p1, s_p2, e_p);
    bus_write(1'b1, 8'h01, s_bufw, s_p1, s_p2, e_p);
    for (int i = 0; i < 200; i++) begin
      a = 1'($urandom);
      if ($urandom_range(0, 9) < 6) begin
        d = 8'($urandom);
        if (!a && d[4] && $urandom_range(0, 5) != 0) d[4] = 1'b0;
        bus_write(a, d, s_bufw, s_p1, s_p2, e_p);
        n_vec++;
        if ({s_p1, s_p2} !== {e_p, 1'b0} || dut_snap() !== model_snap()) begin
          n_err++;
          $display("FAIL rand_write[%0d] a0=%b d=%h got p=%b%b regs=%h exp p=%b0 regs=%h",
                   i, a, d, s_p1, s_p2, dut_snap(), e_p, model_snap());
        end
      end else begin
        @(negedge clk); irr = 8'($urandom); isr = 8'($urandom); poll_word = 8'($urandom);
        bus_read(a, s_dout, e_dout, s_bufr, s_bufw, s_ack, e_ack);
        n_vec++;
        if ({s_dout, s_bufr, s_bufw, s_ack} !== {e_dout, 1'b0, 1'b1, e_ack}) begin
          n_err++;
          $display("FAIL rand_read[%0d] a0=%b got dout=%h dir=%b%b ack=%b exp dout=%h dir=01 ack=%b",
                   i, a, s_dout, s_bufr, s_bufw, s_ack, e_dout, e_ack);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; cs_n = 1; rd_n = 1; wr_n = 1; a0 = 0; din = 0;
    irr = 0; isr = 0; poll_word = 0;
    model_reset();
    test_reset();
    test_init_single();
    test_init_cascade();
    test_ocw12();
    test_poll();
    test_reinit();
    test_reset_mid_write();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
